// File: rtl/stream_min_finder_if.sv
// Handshake bundle for stream_min_finder: sample stream in, min/index result out.
interface stream_min_finder_if #(
    parameter int W = 8,
    parameter int N = 8
);
    localparam int IW = $clog2(N);

    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_min;
    logic [IW-1:0] out_idx;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_min, out_idx, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_min, out_idx, out_valid
    );
endinterface

// File: rtl/stream_min_finder.sv
// Framed streaming minimum finder: reports the minimum of each N-sample frame
// and the index of its first occurrence.
module stream_min_finder #(
    parameter int W = 8,
    parameter int N = 8
) (
    input  logic                clock,
    input  logic                reset,
    stream_min_finder_if.slave  bus
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic {ACCUM, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] count;
    logic [W-1:0]  run_min;
    logic [IW-1:0] run_idx;
    logic [W-1:0]  out_min_r;
    logic [IW-1:0] out_idx_r;

    logic          in_xfer;
    logic          take;
    logic [W-1:0]  cand_min;
    logic [IW-1:0] cand_idx;

    // Candidate includes the sample on the current edge so the frame-final
    // sample participates in the reported result.
    always_comb begin
        in_xfer  = bus.in_valid && (state == ACCUM);
        take     = (count == '0) || (bus.in_data < run_min);
        cand_min = take ? bus.in_data : run_min;
        cand_idx = take ? count : run_idx;
    end

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (in_xfer && (count == LAST))
                    state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            run_min   <= '1;
            run_idx   <= '0;
            out_min_r <= '0;
            out_idx_r <= '0;
        end else if (in_xfer) begin
            run_min <= cand_min;
            run_idx <= cand_idx;
            if (count == LAST) begin
                out_min_r <= cand_min;
                out_idx_r <= cand_idx;
                count     <= '0;
            end else begin
                count <= count + IW'(1);
            end
        end
    end

    assign bus.out_min = out_min_r;
    assign bus.out_idx = out_idx_r;
endmodule
